// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2, K=3 (7,5 octal) convolutional code.
// Used by the frame decoder and intended for the matching encoder block.
//   branch_out    : (input bit, encoder state) -> {c0, c1}
//   branch_metric : expected code pair vs. received samples -> summed distance
package viterbi_pkg;

    localparam int unsigned K          = 3;
    localparam int unsigned NSTATES    = 4;
    localparam logic [2:0]  G0         = 3'o7;
    localparam logic [2:0]  G1         = 3'o5;
    localparam int unsigned SOFT_W_MAX = 8;

    // Encoder state {a,b} = {u[t-1], u[t-2]}
    typedef logic [1:0] vstate_t;

    typedef enum logic {
        ST_ACC,
        ST_DRAIN
    } fsm_state_t;

    function automatic logic [1:0] branch_out(input logic u, input vstate_t s);
        logic [2:0] taps;
        taps = {u, s};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

    // Sample 0 means a strong '0'; an expected '1' measures distance from full scale.
    function automatic logic [SOFT_W_MAX:0] branch_metric(
        input logic [1:0]            e,
        input logic [SOFT_W_MAX-1:0] s0,
        input logic [SOFT_W_MAX-1:0] s1,
        input int unsigned           soft_w
    );
        logic [SOFT_W_MAX-1:0] mx;
        logic [SOFT_W_MAX-1:0] d0;
        logic [SOFT_W_MAX-1:0] d1;
        mx = SOFT_W_MAX'((1 << soft_w) - 1);
        d0 = e[1] ? (mx - s0) : s0;
        d1 = e[0] ? (mx - s1) : s1;
        return {1'b0, d0} + {1'b0, d1};
    endfunction

endpackage

// File: rtl/viterbi_frame_decoder_if.sv
// Symbol-in / decoded-bit-out handshake bundle of the frame decoder.
//   sym_valid/sym_ready/sym                      : channel symbol stream
//   out_valid/out_ready/out_bit/out_last/out_metric : decoded bit stream
// master = environment (demodulator + sink), slave = decoder.
interface viterbi_frame_decoder_if #(
    parameter int unsigned SOFT_W   = 1,
    parameter int unsigned METRIC_W = 6
);
    logic                  sym_valid;
    logic                  sym_ready;
    logic [2*SOFT_W-1:0]   sym;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_bit;
    logic                  out_last;
    logic [METRIC_W-1:0]   out_metric;

    modport master (
        output sym_valid, sym, out_ready,
        input  sym_ready, out_valid, out_bit, out_last, out_metric
    );

    modport slave (
        input  sym_valid, sym, out_ready,
        output sym_ready, out_valid, out_bit, out_last, out_metric
    );
endinterface

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state.
//   pm0_i/bm0_i : metric and branch metric via predecessor with b=0
//   pm1_i/bm1_i : metric and branch metric via predecessor with b=1
//   metric_o    : winning sum, one bit wider than the path metrics
//   dec_o       : 1 when the b=1 predecessor wins (strictly smaller only)
module viterbi_acs #(
    parameter int unsigned METRIC_W = 6,
    parameter int unsigned BM_W     = 2
) (
    input  logic [METRIC_W-1:0] pm0_i,
    input  logic [METRIC_W-1:0] pm1_i,
    input  logic [BM_W-1:0]     bm0_i,
    input  logic [BM_W-1:0]     bm1_i,
    output logic [METRIC_W:0]   metric_o,
    output logic                dec_o
);
    logic [METRIC_W:0] sum0;
    logic [METRIC_W:0] sum1;

    always_comb begin
        sum0     = {1'b0, pm0_i} + (METRIC_W+1)'(bm0_i);
        sum1     = {1'b0, pm1_i} + (METRIC_W+1)'(bm1_i);
        dec_o    = (sum1 < sum0);
        metric_o = dec_o ? sum1 : sum0;
    end
endmodule

// File: rtl/viterbi_frame_decoder.sv
// Frame-based hard/soft Viterbi decoder, rate 1/2, K=3 (7,5), register-exchange survivors.
//   clk   : single clock
//   reset : synchronous, active-low
//   bus   : symbol input and decoded-bit output handshakes (slave side)
// Each frame is INFO_LEN info symbols + 2 tail symbols; after the last tail symbol the
// survivor of state 00 is drained bit by bit, then the decoder re-arms for the next frame.
module viterbi_frame_decoder
    import viterbi_pkg::*;
#(
    parameter int unsigned INFO_LEN = 5,
    parameter int unsigned SOFT_W   = 1,
    parameter int unsigned METRIC_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    viterbi_frame_decoder_if.slave  bus
);
    localparam int unsigned FRAME_LEN = INFO_LEN + 2;
    localparam int unsigned STEP_W    = $clog2(FRAME_LEN);
    localparam int unsigned BM_W      = SOFT_W + 1;

    localparam logic [STEP_W-1:0]   LAST_SYM   = STEP_W'(FRAME_LEN - 1);
    localparam logic [STEP_W-1:0]   LAST_BIT   = STEP_W'(INFO_LEN - 1);
    localparam logic [METRIC_W-1:0] INIT_OTHER = METRIC_W'(2 ** (METRIC_W - 2));
    localparam logic [METRIC_W:0]   HALF       = (METRIC_W+1)'(2 ** (METRIC_W - 1));

    fsm_state_t             state_q, state_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [METRIC_W-1:0]    metric_q [NSTATES];
    logic [METRIC_W-1:0]    metric_d [NSTATES];
    logic [FRAME_LEN-1:0]   surv_q   [NSTATES];
    logic [FRAME_LEN-1:0]   surv_d   [NSTATES];
    logic [INFO_LEN-1:0]    obuf_q, obuf_d;
    logic [METRIC_W-1:0]    omet_q, omet_d;
    logic                   ovalid_q, ovalid_d;
    logic                   sready_q, sready_d;

    logic [SOFT_W_MAX-1:0]  c0_s;
    logic [SOFT_W_MAX-1:0]  c1_s;
    logic [METRIC_W:0]      acs_metric [NSTATES];
    logic [NSTATES-1:0]     acs_dec;
    logic [METRIC_W-1:0]    new_metric [NSTATES];
    logic [FRAME_LEN-1:0]   new_surv   [NSTATES];
    logic                   norm;

    assign c0_s = SOFT_W_MAX'(bus.sym[2*SOFT_W-1:SOFT_W]);
    assign c1_s = SOFT_W_MAX'(bus.sym[SOFT_W-1:0]);

    // New state {u,a} is reached from {a,0} and {a,1}.
    for (genvar gs = 0; gs < NSTATES; gs++) begin : g_acs
        localparam vstate_t P0 = vstate_t'((gs % 2) * 2);
        localparam vstate_t P1 = vstate_t'((gs % 2) * 2 + 1);
        localparam logic    U  = 1'(gs / 2);

        logic [BM_W-1:0] bm0;
        logic [BM_W-1:0] bm1;

        assign bm0 = BM_W'(branch_metric(branch_out(U, P0), c0_s, c1_s, SOFT_W));
        assign bm1 = BM_W'(branch_metric(branch_out(U, P1), c0_s, c1_s, SOFT_W));

        viterbi_acs #(
            .METRIC_W (METRIC_W),
            .BM_W     (BM_W)
        ) u_acs (
            .pm0_i    (metric_q[P0]),
            .pm1_i    (metric_q[P1]),
            .bm0_i    (bm0),
            .bm1_i    (bm1),
            .metric_o (acs_metric[gs]),
            .dec_o    (acs_dec[gs])
        );
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        metric_d = metric_q;
        surv_d   = surv_q;
        obuf_d   = obuf_q;
        omet_d   = omet_q;
        ovalid_d = ovalid_q;

        // Normalise on the wide sums so a metric that just crossed 2^METRIC_W is still seen.
        norm = 1'b1;
        for (int unsigned s = 0; s < NSTATES; s++) begin
            norm = norm & (acs_metric[s] >= HALF);
        end
        for (int unsigned s = 0; s < NSTATES; s++) begin
            vstate_t sv;
            sv             = vstate_t'(s);
            new_metric[s]  = METRIC_W'(acs_metric[s] - (norm ? HALF : '0));
            new_surv[s]    = surv_q[{sv[0], acs_dec[s]}];
            new_surv[s][step_q] = sv[1];
        end

        case (state_q)
            ST_ACC: begin
                if (bus.sym_valid && sready_q) begin
                    metric_d = new_metric;
                    surv_d   = new_surv;
                    if (step_q == LAST_SYM) begin
                        // Tail symbols force the encoder back to 00.
                        obuf_d   = new_surv[0][INFO_LEN-1:0];
                        omet_d   = new_metric[0];
                        ovalid_d = 1'b1;
                        step_d   = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (ovalid_q && bus.out_ready) begin
                    obuf_d = obuf_q >> 1;
                    if (step_q == LAST_BIT) begin
                        ovalid_d = 1'b0;
                        step_d   = '0;
                        state_d  = ST_ACC;
                        for (int unsigned s = 0; s < NSTATES; s++) begin
                            metric_d[s] = (s == 0) ? '0 : INIT_OTHER;
                            surv_d[s]   = '0;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_ACC;
        endcase

        // Registered so ready stays low on the cycle the reset is sampled.
        sready_d = (state_d == ST_ACC);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_ACC;
            step_q   <= '0;
            obuf_q   <= '0;
            omet_q   <= '0;
            ovalid_q <= 1'b0;
            sready_q <= 1'b0;
            for (int unsigned s = 0; s < NSTATES; s++) begin
                metric_q[s] <= (s == 0) ? '0 : INIT_OTHER;
                surv_q[s]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            metric_q <= metric_d;
            surv_q   <= surv_d;
            obuf_q   <= obuf_d;
            omet_q   <= omet_d;
            ovalid_q <= ovalid_d;
            sready_q <= sready_d;
        end
    end

    assign bus.sym_ready  = sready_q;
    assign bus.out_valid  = ovalid_q;
    assign bus.out_bit    = obuf_q[0];
    assign bus.out_last   = ovalid_q && (step_q == LAST_BIT);
    assign bus.out_metric = omet_q;

endmodule

// File: tb/tb_viterbi_frame_decoder.sv
// Directed bench for viterbi_frame_decoder: hard-decision frame table, reset corners,
// a 3-bit soft-decision instance and a 64-bit frame instance with sparse errors.
module tb_viterbi_frame_decoder;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    viterbi_frame_decoder_if #(.SOFT_W(1), .METRIC_W(6)) hif ();
    viterbi_frame_decoder_if #(.SOFT_W(3), .METRIC_W(9)) sif ();
    viterbi_frame_decoder_if #(.SOFT_W(1), .METRIC_W(6)) lif ();

    viterbi_frame_decoder #(.INFO_LEN(5), .SOFT_W(1), .METRIC_W(6)) u_hard (
        .clk (clk), .reset (reset), .bus (hif.slave)
    );
    viterbi_frame_decoder #(.INFO_LEN(5), .SOFT_W(3), .METRIC_W(9)) u_soft (
        .clk (clk), .reset (reset), .bus (sif.slave)
    );
    viterbi_frame_decoder #(.INFO_LEN(64), .SOFT_W(1), .METRIC_W(6)) u_long (
        .clk (clk), .reset (reset), .bus (lif.slave)
    );

    typedef logic [0:6][1:0] hsyms_t;
    typedef logic [0:6][5:0] ssyms_t;

    typedef struct {
        string        name;
        hsyms_t       syms;
        logic [3:0]   rdy;
        logic [0:4]   bits;
        logic [5:0]   metric;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake not seen within cycle bound", name);
    endtask

    task automatic send_hard(input hsyms_t s, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int n;
            n = 0;
            hif.sym_valid = 1'b1;
            hif.sym       = s[i];
            while (hif.sym_ready !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n == 50) timeout("hard sym_ready");
            @(posedge clk); #1;
        end
        hif.sym_valid = 1'b0;
    endtask

    task automatic recv_hard(input logic [3:0] rdy, output logic [0:4] bits,
                             output logic [0:4] lasts, output logic [5:0] met,
                             output int stall_bad, output int ready_bad);
        int         n;
        int         cyc;
        logic       pend;
        logic       pb;
        logic       pl;
        logic [5:0] pm;
        n = 0; cyc = 0; pend = 1'b0; pb = 1'b0; pl = 1'b0; pm = '0;
        bits = '0; lasts = '0; met = '0; stall_bad = 0; ready_bad = 0;
        while (n < 5 && cyc < 100) begin
            hif.out_ready = rdy[cyc % 4];
            if (hif.out_valid === 1'b1) begin
                if (hif.sym_ready !== 1'b0) ready_bad++;
                if (pend && (hif.out_bit !== pb || hif.out_last !== pl || hif.out_metric !== pm))
                    stall_bad++;
                if (hif.out_ready) begin
                    bits[n]  = hif.out_bit;
                    lasts[n] = hif.out_last;
                    met      = hif.out_metric;
                    n++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pb   = hif.out_bit;
                    pl   = hif.out_last;
                    pm   = hif.out_metric;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        hif.out_ready = 1'b0;
        if (n < 5) timeout("hard out_valid");
    endtask

    task automatic run_vec(input vec_t v);
        logic [0:4] bits;
        logic [0:4] lasts;
        logic [5:0] met;
        int         sb;
        int         rb;
        send_hard(v.syms, 7);
        check({v.name, " latency out_valid"}, 64'(hif.out_valid), 64'(1));
        check({v.name, " sym_ready in drain"}, 64'(hif.sym_ready), 64'(0));
        recv_hard(v.rdy, bits, lasts, met, sb, rb);
        check({v.name, " bits"}, 64'(bits), 64'(v.bits));
        check({v.name, " out_last"}, 64'(lasts), 64'(5'b00001));
        check({v.name, " metric"}, 64'(met), 64'(v.metric));
        check({v.name, " stall hold"}, 64'(sb), 64'(0));
        check({v.name, " ready low in drain"}, 64'(rb), 64'(0));
        check({v.name, " out_valid after last"}, 64'(hif.out_valid), 64'(0));
        check({v.name, " sym_ready after last"}, 64'(hif.sym_ready), 64'(1));
    endtask

    function automatic ssyms_t to_soft(input hsyms_t h);
        ssyms_t r;
        for (int i = 0; i < 7; i++) begin
            r[i] = {(h[i][1] ? 3'd7 : 3'd0), (h[i][0] ? 3'd7 : 3'd0)};
        end
        return r;
    endfunction

    task automatic run_soft(input ssyms_t s, output logic [0:4] bits, output logic [8:0] met);
        int n;
        int cyc;
        bits = '0; met = '0;
        for (int i = 0; i < 7; i++) begin
            n = 0;
            sif.sym_valid = 1'b1;
            sif.sym       = s[i];
            while (sif.sym_ready !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n == 50) timeout("soft sym_ready");
            @(posedge clk); #1;
        end
        sif.sym_valid = 1'b0;
        sif.out_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 5 && cyc < 50) begin
            if (sif.out_valid === 1'b1) begin
                bits[n] = sif.out_bit;
                met     = sif.out_metric;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        sif.out_ready = 1'b0;
        if (n < 5) timeout("soft out_valid");
    endtask

    task automatic run_long();
        logic [0:63] info;
        logic [0:63] got;
        logic [1:0]  lsym [66];
        logic        a;
        logic        b;
        logic        u;
        logic        last_ok;
        logic [5:0]  met;
        int          last_cnt;
        int          n;
        int          cyc;
        info = {$urandom, $urandom};
        a = 1'b0; b = 1'b0;
        for (int i = 0; i < 66; i++) begin
            u       = (i < 64) ? info[i] : 1'b0;
            lsym[i] = {u ^ a ^ b, u ^ b};
            b = a;
            a = u;
        end
        // Isolated single-bit errors, ten symbols apart: always correctable.
        for (int k = 0; k < 7; k++) lsym[3 + 10 * k][1] = ~lsym[3 + 10 * k][1];
        for (int i = 0; i < 66; i++) begin
            n = 0;
            lif.sym_valid = 1'b1;
            lif.sym       = lsym[i];
            while (lif.sym_ready !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n == 50) timeout("long sym_ready");
            @(posedge clk); #1;
        end
        lif.sym_valid = 1'b0;
        lif.out_ready = 1'b1;
        got = '0; met = '0; last_cnt = 0; last_ok = 1'b0; n = 0; cyc = 0;
        while (n < 64 && cyc < 200) begin
            if (lif.out_valid === 1'b1) begin
                got[n] = lif.out_bit;
                met    = lif.out_metric;
                if (lif.out_last === 1'b1) begin
                    last_cnt++;
                    if (n == 63) last_ok = 1'b1;
                end
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        lif.out_ready = 1'b0;
        if (n < 64) timeout("long out_valid");
        check("long bits", 64'(got), 64'(info));
        check("long metric", 64'(met), 64'(7));
        check("long out_last count", 64'(last_cnt), 64'(1));
        check("long out_last position", 64'(last_ok), 64'(1));
    endtask

    initial begin
        ssyms_t     ss;
        logic [0:4] sbits;
        logic [8:0] smet;

        vt[0] = '{"clean",   14'b11_10_00_01_01_11_00, 4'b1111, 5'b10110, 6'd0};
        vt[1] = '{"err_s3",  14'b11_10_10_01_01_11_00, 4'b1111, 5'b10110, 6'd1};
        vt[2] = '{"err_s16", 14'b01_10_00_01_01_10_00, 4'b1111, 5'b10110, 6'd2};
        vt[3] = '{"b2b_a",   14'b00_11_10_11_11_10_11, 4'b0101, 5'b01001, 6'd0};
        vt[4] = '{"b2b_b",   14'b11_10_00_01_01_11_00, 4'b1010, 5'b10110, 6'd0};
        vt[5] = '{"ones",    14'b11_01_10_10_10_01_11, 4'b1011, 5'b11111, 6'd0};

        hif.sym_valid = 1'b0; hif.sym = '0; hif.out_ready = 1'b0;
        sif.sym_valid = 1'b0; sif.sym = '0; sif.out_ready = 1'b0;
        lif.sym_valid = 1'b0; lif.sym = '0; lif.out_ready = 1'b0;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset sym_ready", 64'(hif.sym_ready), 64'(0));
        check("reset out_valid", 64'(hif.out_valid), 64'(0));
        check("reset out_bit", 64'(hif.out_bit), 64'(0));
        check("reset out_last", 64'(hif.out_last), 64'(0));
        check("reset out_metric", 64'(hif.out_metric), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        check("sym_ready after release", 64'(hif.sym_ready), 64'(1));

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Reset after four accepted symbols, then a clean frame must decode exactly.
        send_hard(vt[0].syms, 4);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midframe reset sym_ready", 64'(hif.sym_ready), 64'(0));
        check("midframe reset out_valid", 64'(hif.out_valid), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        run_vec(vt[0]);

        // Reset while draining with bits still pending.
        send_hard(vt[1].syms, 7);
        hif.out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        hif.out_ready = 1'b0;
        check("drain bit before reset", 64'(hif.out_bit), 64'(1));
        reset = 1'b0;
        @(posedge clk); #1;
        check("drain reset out_valid", 64'(hif.out_valid), 64'(0));
        check("drain reset out_bit", 64'(hif.out_bit), 64'(0));
        check("drain reset out_last", 64'(hif.out_last), 64'(0));
        check("drain reset out_metric", 64'(hif.out_metric), 64'(0));
        check("drain reset sym_ready", 64'(hif.sym_ready), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        run_vec(vt[1]);

        // Soft decision, 3-bit samples.
        ss = to_soft(vt[0].syms);
        run_soft(ss, sbits, smet);
        check("soft clean bits", 64'(sbits), 64'(5'b10110));
        check("soft clean metric", 64'(smet), 64'(0));

        ss = to_soft(vt[0].syms);
        ss[0] = {3'd3, 3'd3};
        ss[1] = {3'd3, ss[1][2:0]};
        run_soft(ss, sbits, smet);
        check("soft weak bits", 64'(sbits), 64'(5'b10110));
        check("soft weak metric", 64'(smet), 64'(12));

        ss = to_soft(vt[0].syms);
        ss[0] = {3'd0, 3'd0};
        ss[1] = {3'd0, ss[1][2:0]};
        run_soft(ss, sbits, smet);
        check("soft strong bits differ", 64'(sbits != 5'b10110), 64'(1));
        check("soft strong metric", 64'(smet), 64'(14));

        run_long();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
